i2c_master_tx: RTL and testbench

Single-master I2C write initiator. It drives the bus toward the I2C slave receiver: START, 7-bit address plus write bit, ACK check, one data byte, ACK check, STOP. The block sits between a local command interface (start/addr/data) and the open-drain SDA line. SCL is generated by this block, and it is the only master on the bus.

---
 rtl/i2c_master_tx_if.sv | 12 +
 rtl/i2c_master_tx.sv | 162 ++++++++++++++++
 tb/tb_i2c_master_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_tx_if.sv
// rtl/i2c_master_tx_if.sv - command handshake bundle for the I2C write master
interface i2c_master_tx_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (output start, addr, data_in, input busy, done, nack);
  modport slave  (input start, addr, data_in, output busy, done, nack);
endinterface

// File: rtl/i2c_master_tx.sv
// rtl/i2c_master_tx.sv - single-master I2C write: START, addr+W, ACK, one byte, ACK, STOP
module i2c_master_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  i2c_master_tx_if.slave cmd,
  output logic           scl,
  inout  wire            sda
);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    q_q, q_d;
  logic [2:0]    bits_q, bits_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic          tick;
  logic          sda_in;

  assign sda_in = sda;
  assign tick   = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    q_d      = q_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    nack_d   = nack_q;
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;

    if (state_q == S_IDLE) begin
      div_d  = '0;
      q_d    = '0;
      bits_d = '0;
      if (cmd.start) begin
        state_d = S_START;
        shift_d = {cmd.addr, 1'b0};
        data_d  = cmd.data_in;
        nack_d  = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      // done lands on the last clk of STOP q3 so the accept-to-done count is exactly 80*CLK_DIV
      if (state_q == S_STOP && q_q == 2'd3 && div_q == DW'(CLK_DIV - 2)) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      if (tick) begin
        q_d = q_q + 2'd1;
        case (state_q)
          S_START: begin
            if (q_q == 2'd3) state_d = S_ADDR;
          end
          S_ADDR, S_DATA: begin
            if (q_q == 2'd3) begin
              shift_d = {shift_q[6:0], 1'b0};
              bits_d  = bits_q + 3'd1;
              if (bits_q == 3'd7)
                state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
            end
          end
          S_ADDR_ACK, S_DATA_ACK: begin
            if (q_q == 2'd2) nack_d = nack_q | sda_in;
            if (q_q == 2'd3) begin
              if (nack_q || state_q == S_DATA_ACK) begin
                state_d = S_STOP;
              end else begin
                state_d = S_DATA;
                shift_d = data_q;
              end
            end
          end
          S_STOP: begin
            if (q_q == 2'd3) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Bus levels are decoded from the upcoming position so they change on the quarter edge.
    case (state_d)
      S_START: begin
        scl_d    = (q_d != 2'd3);
        sda_oe_d = q_d[1];
      end
      S_ADDR, S_DATA: begin
        scl_d    = (q_d == 2'd1) || (q_d == 2'd2);
        sda_oe_d = ~shift_d[7];
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        scl_d    = (q_d == 2'd1) || (q_d == 2'd2);
        sda_oe_d = 1'b0;
      end
      S_STOP: begin
        scl_d    = (q_d != 2'd0);
        sda_oe_d = ~q_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      q_q      <= '0;
      bits_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      q_q      <= q_d;
      bits_q   <= bits_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end

  assign scl      = scl_q;
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign cmd.busy = busy_q;
  assign cmd.done = done_q;
  assign cmd.nack = nack_q;
endmodule

// File: tb/tb_i2c_master_tx.sv
// tb/tb_i2c_master_tx.sv - directed self-checking bench for i2c_master_tx with an ACK/NACK slave model
module tb_i2c_master_tx;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl;
  wire  sda;
  logic drv = 1'b0;

  i2c_master_tx_if cmd_if();

  i2c_master_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .scl   (scl),
    .sda   (sda)
  );

  pullup (sda);
  assign sda = drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave model, sampled 2 time units after each rising clk edge.
  int          rises = 0;
  int          starts = 0;
  int          stops = 0;
  logic [31:0] rx = '0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        cur_sda;
  logic        mon_clr = 1'b0;
  logic        ack_a = 1'b1;
  logic        ack_d = 1'b1;

  always begin
    @(posedge clk);
    #2;
    cur_sda = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (mon_clr) begin
      rises  = 0;
      starts = 0;
      stops  = 0;
      rx     = '0;
      drv    = 1'b0;
    end else begin
      if (scl === 1'b1 && prev_scl && prev_sda && !cur_sda) starts++;
      if (scl === 1'b1 && prev_scl && !prev_sda && cur_sda) stops++;
      if (scl === 1'b1 && !prev_scl) begin
        rx = {rx[30:0], cur_sda};
        rises++;
      end
      if (scl === 1'b0 && prev_scl) begin
        if (rises == 8)  drv = ack_a;
        if (rises == 9)  drv = 1'b0;
        if (rises == 17) drv = ack_d;
        if (rises == 18) drv = 1'b0;
      end
    end
    prev_scl = (scl === 1'b1);
    prev_sda = cur_sda;
  end

  int total = 0;
  int bad = 0;
  int acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_txn(input logic [6:0] a, input logic [7:0] d, input logic aa, input logic ad);
    @(negedge clk);
    cmd_if.start   = 1'b1;
    cmd_if.addr    = a;
    cmd_if.data_in = d;
    ack_a          = aa;
    ack_d          = ad;
    mon_clr        = 1'b1;
    acc            = cyc;
    @(negedge clk);
    cmd_if.start = 1'b0;
    mon_clr      = 1'b0;
    chk("busy_after_accept", {31'd0, cmd_if.busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (cmd_if.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cyc - acc, exp_lat);
    chk("busy_low_at_done", {31'd0, cmd_if.busy}, 32'd0);
  endtask

  task automatic check_bus(input string tag, input int exp_rises, input logic [31:0] exp_rx,
                           input logic exp_nack);
    chk({tag, "_rises"}, rises, exp_rises);
    chk({tag, "_bits"}, rx, exp_rx);
    chk({tag, "_nack"}, {31'd0, cmd_if.nack}, {31'd0, exp_nack});
    chk({tag, "_start_cond"}, starts, 32'd1);
    chk({tag, "_stop_cond"}, stops, 32'd1);
  endtask

  logic [31:0] exp_full;
  logic [31:0] exp_anack;
  logic [31:0] exp_dnack;
  logic [31:0] exp_alt;
  int          busy_cnt;
  int          n;

  initial begin
    exp_full  = {13'd0, 8'hA0, 1'b0, 8'hA5, 1'b0, 1'b0};
    exp_anack = {22'd0, 8'hA0, 1'b1, 1'b0};
    exp_dnack = {13'd0, 8'hA0, 1'b0, 8'hA5, 1'b1, 1'b0};
    exp_alt   = {13'd0, 8'h24, 1'b0, 8'h3C, 1'b0, 1'b0};

    cmd_if.start   = 1'b0;
    cmd_if.addr    = '0;
    cmd_if.data_in = '0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_busy", {31'd0, cmd_if.busy}, 32'd0);
    chk("rst_done", {31'd0, cmd_if.done}, 32'd0);
    chk("rst_nack", {31'd0, cmd_if.nack}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full write, both slots ACKed
    begin_txn(7'h50, 8'hA5, 1'b1, 1'b1);
    wait_done("lat_full", 320);
    check_bus("full", 19, exp_full, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, cmd_if.done}, 32'd0);

    // Address NACK
    begin_txn(7'h50, 8'hA5, 1'b0, 1'b1);
    wait_done("lat_addr_nack", 176);
    check_bus("anack", 10, exp_anack, 1'b1);
    repeat (5) @(negedge clk);
    chk("nack_hold", {31'd0, cmd_if.nack}, 32'd1);

    // Data NACK
    begin_txn(7'h50, 8'hA5, 1'b1, 1'b0);
    wait_done("lat_data_nack", 320);
    check_bus("dnack", 19, exp_dnack, 1'b1);

    // start while busy is ignored
    begin_txn(7'h50, 8'hA5, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    cmd_if.start   = 1'b1;
    cmd_if.addr    = 7'h7F;
    cmd_if.data_in = 8'hFF;
    @(negedge clk);
    cmd_if.start = 1'b0;
    wait_done("lat_ignore", 320);
    check_bus("ignore", 19, exp_full, 1'b0);
    busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_if.busy === 1'b1) busy_cnt++;
    end
    chk("no_second_txn", busy_cnt, 32'd0);

    // Reset in the middle of the data byte
    begin_txn(7'h50, 8'hA5, 1'b1, 1'b1);
    n = 0;
    while (rises < 13 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_bit3", {31'd0, (rises >= 13)}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_scl", {31'd0, scl}, 32'd1);
    chk("midrst_sda", {31'd0, sda}, 32'd1);
    chk("midrst_busy", {31'd0, cmd_if.busy}, 32'd0);
    chk("midrst_nack", {31'd0, cmd_if.nack}, 32'd0);
    chk("midrst_done", {31'd0, cmd_if.done}, 32'd0);
    reset = 1'b0;
    begin_txn(7'h12, 8'h3C, 1'b1, 1'b1);
    wait_done("lat_after_rst", 320);
    check_bus("after_rst", 19, exp_alt, 1'b0);

    // Back-to-back: start held over the done cycle and the one after it
    begin_txn(7'h50, 8'hA5, 1'b1, 1'b1);
    wait_done("lat_b2b_first", 320);
    check_bus("b2b_first", 19, exp_full, 1'b0);
    chk("gap_scl_done", {31'd0, scl}, 32'd1);
    chk("gap_sda_done", {31'd0, sda}, 32'd1);
    cmd_if.start   = 1'b1;
    cmd_if.addr    = 7'h12;
    cmd_if.data_in = 8'h3C;
    @(negedge clk);
    chk("gap_scl_next", {31'd0, scl}, 32'd1);
    chk("gap_sda_next", {31'd0, sda}, 32'd1);
    mon_clr = 1'b1;
    acc     = cyc;
    @(negedge clk);
    cmd_if.start = 1'b0;
    mon_clr      = 1'b0;
    chk("b2b_busy", {31'd0, cmd_if.busy}, 32'd1);
    wait_done("lat_b2b_second", 320);
    check_bus("b2b_second", 19, exp_alt, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
